// File: rtl/act_unit_vec_if.sv
// Stream bundle for act_unit_vec: mode/data input handshake and
// activated-data output handshake.
interface act_unit_vec_if #(
  parameter int LANES = 4,
  parameter int W     = 8
);
  logic [2:0]         act_type;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_data;

  modport master (
    output act_type, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  act_type, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/act_unit_vec.sv
// Multi-lane saturating activation unit: 2-stage valid/ready pipeline
// with per-beat mode and a saturated-lane counter.
module act_unit_vec #(
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 0,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  act_unit_vec_if.slave        s,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] sat_count
);
  localparam int W       = DATA_WIDTH;
  localparam int MAXV    = (1 << (W-1)) - 1;
  localparam int HALF    = 1 << (W-2);
  localparam int SIX_RAW = 6 << FRAC_BITS;
  localparam int SIXV    = (SIX_RAW < MAXV) ? SIX_RAW : MAXV;

  localparam logic signed [W-1:0] MAXV_S  = W'(MAXV);
  localparam logic signed [W-1:0] NMAXV_S = W'(-MAXV);
  localparam logic signed [W-1:0] HALF_S  = W'(HALF);
  localparam logic signed [W-1:0] NHALF_S = W'(-HALF);
  localparam logic signed [W-1:0] SIX_S   = W'(SIXV);
  localparam logic signed [W-1:0] ZERO_S  = '0;
  localparam logic signed [W:0]   MAXV_X  = (W+1)'(MAXV);
  localparam logic signed [W:0]   NMAXV_X = (W+1)'(-MAXV);

  // Returns {sat, y}; every clamp happens before any narrowing.
  function automatic logic [W:0] act_f(
    input logic signed [W-1:0] x,
    input logic [2:0]          t
  );
    logic signed [W-1:0] y;
    logic signed [W:0]   x2;
    logic                sat;
    y   = x;
    sat = 1'b0;
    x2  = {x, 1'b0};
    case (t)
      3'd1: if (x < ZERO_S) y = ZERO_S;
      3'd2: begin
        if (x < ZERO_S) y = ZERO_S;
        else if (x > SIX_S) begin
          y   = SIX_S;
          sat = 1'b1;
        end
      end
      3'd3: begin
        if (x < NHALF_S) begin
          y   = ZERO_S;
          sat = 1'b1;
        end else if (x > HALF_S) begin
          y   = MAXV_S;
          sat = 1'b1;
        end else y = HALF_S + (x >>> 1);
      end
      3'd4: begin
        if (x < NHALF_S) begin
          y   = NMAXV_S;
          sat = 1'b1;
        end else if (x > HALF_S) begin
          y   = MAXV_S;
          sat = 1'b1;
        end else if (x2 > MAXV_X) begin
          y   = MAXV_S;
          sat = 1'b1;
        end else if (x2 < NMAXV_X) begin
          y   = NMAXV_S;
          sat = 1'b1;
        end else y = x2[W-1:0];
      end
      3'd5: if (x < ZERO_S) y = x >>> LEAKY_SHIFT;
      3'd6: if (x > ZERO_S) y = ZERO_S;
      default: y = x;
    endcase
    return {sat, y};
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [LANES*W-1:0]   s1_data_q, s1_data_d;
  logic [2:0]           s1_type_q, s1_type_d;
  logic                 out_valid_q, out_valid_d;
  logic [LANES*W-1:0]   out_data_q, out_data_d;
  logic [LANES-1:0]     sat_q, sat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   sum;
  logic [LANES*W-1:0]   f_data;
  logic [LANES-1:0]     f_sat;
  logic                 s2_can, in_fire, adv, out_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W:0] r;
    assign r                = act_f(s1_data_q[g*W +: W], s1_type_q);
    assign f_data[g*W +: W] = r[W-1:0];
    assign f_sat[g]         = r[W];
  end

  assign s2_can     = !out_valid_q || s.out_ready;
  assign s.in_ready = !s1_valid_q || s2_can;
  assign in_fire    = s.in_valid && s.in_ready;
  assign adv        = s1_valid_q && s2_can;
  assign out_fire   = out_valid_q && s.out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_type_d   = s1_type_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = s.in_data;
      s1_type_d  = s.act_type;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
    if (adv) begin
      out_valid_d = 1'b1;
      out_data_d  = f_data;
      sat_d       = f_sat;
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // One extra bit catches the carry so the counter sticks at all-ones.
  always_comb begin
    sum = {1'b0, cnt_q};
    for (int i = 0; i < LANES; i++)
      sum = sum + (CNT_WIDTH+1)'(sat_q[i]);
    cnt_d = cnt_q;
    if (clr_stats) cnt_d = '0;
    else if (out_fire)
      cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_type_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_type_q   <= s1_type_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign sat_count   = cnt_q;
endmodule

// File: tb/tb_act_unit_vec.sv
// Self-checking bench for act_unit_vec against an integer reference
// model with a scoreboard queue of expected beats.
module tb_act_unit_vec;
  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int FRAC  = 0;
  localparam int LS    = 3;
  localparam int CW    = 4;
  localparam int MAXV  = (1 << (W-1)) - 1;
  localparam int HALF  = 1 << (W-2);
  localparam int CMAX  = (1 << CW) - 1;
  localparam int SIX   = ((6 << FRAC) < MAXV) ? (6 << FRAC) : MAXV;

  typedef logic [LANES*W-1:0] vec_t;
  typedef struct {
    vec_t d;
    int   s;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] sat_count;

  always #5 clk = ~clk;

  act_unit_vec_if #(.LANES(LANES), .W(W)) bus ();

  act_unit_vec #(
    .LANES(LANES), .DATA_WIDTH(W), .FRAC_BITS(FRAC),
    .LEAKY_SHIFT(LS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(bus),
    .clr_stats(clr_stats), .sat_count(sat_count)
  );

  int    total = 0;
  int    bad = 0;
  beat_t q[$];
  int    mcnt = 0;
  int    accepted = 0;
  logic  ofire;
  vec_t  odata, oexp;
  int    osat;
  int    edges[11] = '{-128, -65, -64, -1, 0, 1, 6, 7, 64, 65, 127};

  function automatic int fdiv(int x, int d);
    int r;
    r = x / d;
    if ((x % d) != 0 && x < 0) r = r - 1;
    return r;
  endfunction

  function automatic int clampi(int v, int lo, int hi, output int sat);
    sat = 0;
    if (v > hi) begin sat = 1; return hi; end
    if (v < lo) begin sat = 1; return lo; end
    return v;
  endfunction

  function automatic int ref_f(int x, int m, output int sat);
    sat = 0;
    case (m)
      1: return (x < 0) ? 0 : x;
      2: begin
        if (x < 0) return 0;
        return clampi(x, 0, SIX, sat);
      end
      3: begin
        if (x < -HALF) begin sat = 1; return 0; end
        if (x > HALF) begin sat = 1; return MAXV; end
        return HALF + fdiv(x, 2);
      end
      4: begin
        if (x < -HALF) begin sat = 1; return -MAXV; end
        if (x > HALF) begin sat = 1; return MAXV; end
        return clampi(2 * x, -MAXV, MAXV, sat);
      end
      5: return (x < 0) ? fdiv(x, 1 << LS) : x;
      6: return (x > 0) ? 0 : x;
      default: return x;
    endcase
  endfunction

  function automatic beat_t model(vec_t din, logic [2:0] m);
    beat_t b;
    b.d = '0;
    b.s = 0;
    for (int i = 0; i < LANES; i++) begin
      int x, y, s;
      x = int'($signed(din[i*W +: W]));
      y = ref_f(x, int'(m), s);
      b.d[i*W +: W] = y[W-1:0];
      b.s += s;
    end
    return b;
  endfunction

  function automatic vec_t pack(int a, int b, int c, int d);
    vec_t v;
    v[0 +: W]   = a[W-1:0];
    v[W +: W]   = b[W-1:0];
    v[2*W +: W] = c[W-1:0];
    v[3*W +: W] = d[W-1:0];
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      int e;
      e = edges[$urandom % 11];
      v[i*W +: W] = ($urandom % 2 == 1) ? W'($urandom) : e[W-1:0];
    end
    return v;
  endfunction

  // Advance one clock: record handshakes at the falling edge, update the
  // model, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    ofire = 1'b0;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        ofire = 1'b1;
        odata = bus.out_data;
        if (q.size() > 0) begin
          oexp = q[0].d;
          osat = q[0].s;
          void'(q.pop_front());
        end else begin
          oexp = 'x;
          osat = 0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        q.push_back(model(bus.in_data, bus.act_type));
      end
      if (clr_stats) mcnt = 0;
      else if (ofire) mcnt = (mcnt + osat > CMAX) ? CMAX : mcnt + osat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(logic [2:0] m, vec_t d);
    bus.act_type  = m;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ofire) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.out_data !== '0) begin
      bad++;
      $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
    total++;
    if (sat_count !== '0) begin
      bad++;
      $display("FAIL reset_sat_count: got %0d want 0", sat_count);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_latency();
    int nf, first, last;
    bus.out_ready = 1'b1;
    bus.act_type  = 3'd1;
    bus.in_data   = pack(-5, 0, 7, 127);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_early_valid: got %b want 0", bus.out_valid);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== pack(0, 0, 7, 127)) begin
      bad++;
      $display("FAIL lat_relu: got v=%b %h want v=1 %h",
               bus.out_valid, bus.out_data, pack(0, 0, 7, 127));
    end
    tick();
    total++;
    if (!ofire || odata !== oexp) begin
      bad++;
      $display("FAIL lat_handshake: got fire=%b %h want fire=1 %h",
               ofire, odata, oexp);
    end
    nf = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = (k < 8);
      bus.act_type = 3'd1;
      bus.in_data  = rnd_vec();
      tick();
      if (ofire) begin
        nf++;
        if (first < 0) first = k;
        last = k;
        total++;
        if (odata !== oexp) begin
          bad++;
          $display("FAIL b2b_data: got %h want %h", odata, oexp);
        end
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (nf != 8 || last - first != 7) begin
      bad++;
      $display("FAIL b2b_count: got n=%0d span=%0d want n=8 span=7",
               nf, last - first);
    end
  endtask

  task automatic test_sat_edges();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    one_beat(3'd4, pack(64, -64, 65, 10));
    total++;
    if (!ofire || odata !== pack(127, -127, 127, 20) || sat_count !== 4'd3) begin
      bad++;
      $display("FAIL tanh: got %h cnt=%0d want %h cnt=3",
               odata, sat_count, pack(127, -127, 127, 20));
    end
    one_beat(3'd3, pack(-65, -64, 64, 65));
    total++;
    if (!ofire || odata !== pack(0, 32, 96, 127) || sat_count !== 4'd5) begin
      bad++;
      $display("FAIL sigmoid: got %h cnt=%0d want %h cnt=5",
               odata, sat_count, pack(0, 32, 96, 127));
    end
    one_beat(3'd2, pack(7, 6, -1, 3));
    total++;
    if (!ofire || odata !== pack(6, 6, 0, 3) || sat_count !== 4'd6) begin
      bad++;
      $display("FAIL relu6: got %h cnt=%0d want %h cnt=6",
               odata, sat_count, pack(6, 6, 0, 3));
    end
    one_beat(3'd5, pack(-8, -1, -128, 5));
    total++;
    if (!ofire || odata !== pack(-1, -1, -16, 5) || sat_count !== 4'd6) begin
      bad++;
      $display("FAIL leaky: got %h cnt=%0d want %h cnt=6",
               odata, sat_count, pack(-1, -1, -16, 5));
    end
    one_beat(3'd6, pack(-128, 1, 0, -3));
    total++;
    if (!ofire || odata !== pack(-128, 0, 0, -3)) begin
      bad++;
      $display("FAIL mirror: got %h want %h", odata, pack(-128, 0, 0, -3));
    end
  endtask

  task automatic test_back_to_back();
    int a0, prev, nf;
    a0 = accepted;
    bus.out_ready = 1'b0;
    bus.act_type  = 3'd4;
    bus.in_data   = rnd_vec();
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      prev = accepted;
      tick();
      if (accepted != prev) begin
        bus.in_data  = rnd_vec();
        bus.act_type = 3'($urandom);
      end
      if (k >= 1) begin
        total++;
        if (bus.out_valid !== 1'b1 || q.size() == 0 || bus.out_data !== q[0].d) begin
          bad++;
          $display("FAIL stall_hold: got v=%b %h", bus.out_valid, bus.out_data);
        end
      end
    end
    total++;
    if (accepted - a0 != 2 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: got acc=%0d rdy=%b want acc=2 rdy=0",
               accepted - a0, bus.in_ready);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    nf = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ofire) begin
        nf++;
        total++;
        if (odata !== oexp) begin
          bad++;
          $display("FAIL drain_order: got %h want %h", odata, oexp);
        end
      end
    end
    total++;
    if (nf != 2 || q.size() != 0) begin
      bad++;
      $display("FAIL drain_count: got %0d left=%0d want 2 left=0", nf, q.size());
    end
  endtask

  task automatic test_counter();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    one_beat(3'd4, pack(100, 100, -100, -100));
    one_beat(3'd4, pack(100, 100, -100, -100));
    one_beat(3'd4, pack(64, -64, 65, 10));
    one_beat(3'd4, pack(64, -64, 65, 10));
    total++;
    if (sat_count !== 4'd14) begin
      bad++;
      $display("FAIL cnt_14: got %0d want 14", sat_count);
    end
    one_beat(3'd4, pack(64, -64, 65, 10));
    total++;
    if (sat_count !== 4'd15) begin
      bad++;
      $display("FAIL cnt_sat: got %0d want 15", sat_count);
    end
    one_beat(3'd3, pack(-100, 100, 0, 0));
    total++;
    if (sat_count !== 4'd15) begin
      bad++;
      $display("FAIL cnt_hold: got %0d want 15", sat_count);
    end
    bus.out_ready = 1'b0;
    bus.act_type  = 3'd4;
    bus.in_data   = pack(100, 100, -100, -100);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    total++;
    if (!ofire || sat_count !== 4'd0) begin
      bad++;
      $display("FAIL cnt_clr_prio: got fire=%b cnt=%0d want fire=1 cnt=0",
               ofire, sat_count);
    end
  endtask

  task automatic test_reset_midstream();
    int nv;
    bus.out_ready = 1'b0;
    bus.act_type  = 3'd4;
    bus.in_data   = pack(100, 100, -100, -100);
    bus.in_valid  = 1'b1;
    tick();
    tick();
    tick();
    one_beat_cnt_prep();
    rst_n = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || sat_count !== '0) begin
      bad++;
      $display("FAIL rst_mid: got v=%b %h cnt=%0d want v=0 0 cnt=0",
               bus.out_valid, bus.out_data, sat_count);
    end
    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ofire) nv++;
    end
    total++;
    if (nv != 0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_stale: got outs=%0d rdy=%b want outs=0 rdy=1",
               nv, bus.in_ready);
    end
  endtask

  task automatic one_beat_cnt_prep();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.act_type  = 3'($urandom);
      bus.in_data   = rnd_vec();
      clr_stats     = ($urandom % 50) == 0;
      tick();
      if (ofire) begin
        total++;
        if (odata !== oexp) begin
          bad++;
          $display("FAIL rand_data: got %h want %h", odata, oexp);
        end
      end
      total++;
      if (sat_count !== CW'(mcnt)) begin
        bad++;
        $display("FAIL rand_cnt: got %0d want %0d", sat_count, mcnt);
      end
    end
    clr_stats     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ofire) begin
        total++;
        if (odata !== oexp) begin
          bad++;
          $display("FAIL rand_drain: got %h want %h", odata, oexp);
        end
      end
    end
    total++;
    if (q.size() != 0 || sat_count !== CW'(mcnt)) begin
      bad++;
      $display("FAIL rand_end: got left=%0d cnt=%0d want left=0 cnt=%0d",
               q.size(), sat_count, mcnt);
    end
  endtask

  initial begin
    bus.act_type  = 3'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_sat_edges();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
